conv2d_stream: RTL and testbench

- Parametrised 2D convolution engine: next generation of the team's fixed 9x9, 3x3-Gaussian convolver.
- Image size, pixel width, kernel size and kernel coefficients are all configurable; kernel coefficients are signed and loaded at run time.
- Normalisation is a run-time arithmetic shift; border handling is selectable (zero-pad or replicate).
- Results stream out over a valid/ready interface instead of a flat output bus. The block sits between the frame buffer and the downstream filter chain.

---
 rtl/conv2d_stream.sv | 180 ++++++++++++++++++
 tb/tb_conv2d_stream.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream.sv
// Streaming KxK convolver: one tap per cycle over a latched frame,
// results normalised, saturated and handed out over valid/ready.
module conv2d_stream #(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 9,
  parameter int IMG_H   = 9,
  parameter int K       = 3,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [IMG_W*IMG_H*DATA_W-1:0] img_in,
  input  logic [K*K*COEF_W-1:0]         kernel_in,
  input  logic [SHIFT_W-1:0]            norm_shift,
  input  logic                          border_mode,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  output logic                          done
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(K*K) + 1;
  localparam int NT    = K * K;
  localparam int TW    = $clog2(NT + 1);
  localparam int KW    = $clog2(K);
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int HALF  = K / 2;
  localparam int PW    = DATA_W + COEF_W + 1;
  localparam logic signed [ACC_W-1:0] MAXV =
    ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    EMIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [IMG_W*IMG_H*DATA_W-1:0] img_q;
  logic [K*K*COEF_W-1:0]         kern_q;
  logic [SHIFT_W-1:0]            shift_q;
  logic                          mode_q;
  logic [RW-1:0]                 r;
  logic [CW-1:0]                 c;
  logic [KW-1:0]                 ti, tj;
  logic [TW-1:0]                 tap;
  logic signed [ACC_W-1:0]       acc;

  logic                          taps_done;
  logic                          last_px;
  int                            sr, sc;
  logic                          oob;
  logic [DATA_W-1:0]             pix;
  logic signed [COEF_W-1:0]      coef;
  logic signed [PW-1:0]          prod;
  logic signed [ACC_W-1:0]       acc_sh;
  logic [DATA_W-1:0]             sat;

  assign taps_done = (tap == TW'(NT));
  assign last_px   = (r == RW'(IMG_H - 1)) && (c == CW'(IMG_W - 1));
  assign busy      = (state == MAC) || (state == EMIT);
  assign out_valid = (state == EMIT);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = MAC;
      MAC:  if (taps_done) state_n = EMIT;
      EMIT: if (out_ready) state_n = last_px ? DONE : MAC;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Coordinates are always clamped so the select stays in range;
  // zero-pad mode then masks the out-of-bounds pixel.
  always_comb begin
    sr  = int'(r) + int'(ti) - HALF;
    sc  = int'(c) + int'(tj) - HALF;
    oob = (sr < 0) || (sr > IMG_H - 1) ||
          (sc < 0) || (sc > IMG_W - 1);
    if (sr < 0)              sr = 0;
    else if (sr > IMG_H - 1) sr = IMG_H - 1;
    if (sc < 0)              sc = 0;
    else if (sc > IMG_W - 1) sc = IMG_W - 1;
    pix = img_q[(sr*IMG_W + sc)*DATA_W +: DATA_W];
    if (oob && !mode_q) pix = '0;
    coef = kern_q[(int'(ti)*K + int'(tj))*COEF_W +: COEF_W];
    prod = $signed({1'b0, pix}) * coef;
  end

  always_comb begin
    acc_sh = acc >>> shift_q;
    if (acc_sh[ACC_W-1])    sat = '0;
    else if (acc_sh > MAXV) sat = '1;
    else                    sat = acc_sh[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_q    <= '0;
      kern_q   <= '0;
      shift_q  <= '0;
      mode_q   <= 1'b0;
      r        <= '0;
      c        <= '0;
      ti       <= '0;
      tj       <= '0;
      tap      <= '0;
      acc      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            img_q   <= img_in;
            kern_q  <= kernel_in;
            shift_q <= norm_shift;
            mode_q  <= border_mode;
            r       <= '0;
            c       <= '0;
            ti      <= '0;
            tj      <= '0;
            tap     <= '0;
            acc     <= '0;
          end
        end
        MAC: begin
          if (!taps_done) begin
            acc <= acc + ACC_W'(prod);
            tap <= tap + 1'b1;
            if (tj == KW'(K - 1)) begin
              tj <= '0;
              ti <= (ti == KW'(K - 1)) ? '0 : ti + 1'b1;
            end else begin
              tj <= tj + 1'b1;
            end
          end else begin
            out_data <= sat;
            out_last <= last_px;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_px) begin
              out_last <= 1'b0;
            end else begin
              acc <= '0;
              tap <= '0;
              ti  <= '0;
              tj  <= '0;
              if (c == CW'(IMG_W - 1)) begin
                c <= '0;
                r <= r + 1'b1;
              end else begin
                c <= c + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed frames for conv2d_stream with hand-derived pixel values,
// stall, spurious start and mid-frame abort.
module tb_conv2d_stream;

  localparam int DATA_W  = 8;
  localparam int IMG_W   = 9;
  localparam int IMG_H   = 9;
  localparam int K       = 3;
  localparam int COEF_W  = 8;
  localparam int SHIFT_W = 5;
  localparam int NPX     = IMG_W * IMG_H;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          start = 1'b0;
  logic [IMG_W*IMG_H*DATA_W-1:0] img_in = '0;
  logic [K*K*COEF_W-1:0]         kernel_in = '0;
  logic [SHIFT_W-1:0]            norm_shift = '0;
  logic                          border_mode = 1'b0;
  logic                          busy;
  logic                          out_valid;
  logic                          out_ready = 1'b1;
  logic [DATA_W-1:0]             out_data;
  logic                          out_last;
  logic                          done;

  conv2d_stream #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .K(K), .COEF_W(COEF_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_in(img_in), .kernel_in(kernel_in),
    .norm_shift(norm_shift), .border_mode(border_mode),
    .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int img_ref[NPX];
  int got_px[NPX];
  int got_last[NPX];
  int nhs;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic set_kern(input int k0, input int k1, input int k2,
                          input int k3, input int k4, input int k5,
                          input int k6, input int k7, input int k8);
    int kv[9];
    kv = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
    for (int i = 0; i < 9; i++)
      kernel_in[i*COEF_W +: COEF_W] = COEF_W'(kv[i]);
  endtask

  task automatic load_img();
    for (int i = 0; i < NPX; i++)
      img_in[i*DATA_W +: DATA_W] = DATA_W'(img_ref[i]);
  endtask

  task automatic fill_img(input int v);
    for (int i = 0; i < NPX; i++) img_ref[i] = v;
    load_img();
  endtask

  task automatic rand_img();
    for (int i = 0; i < NPX; i++) img_ref[i] = $urandom_range(0, 255);
    load_img();
  endtask

  // abort_at >= 0 asserts rst when that pixel is offered
  task automatic run_frame(input bit stall, input bit poke,
                           input int abort_at);
    int  hs_cyc = -10;
    int  stalls = 0;
    int  held = 0;
    bit  fin = 0;
    nhs = 0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    img_in      = ~img_in;
    kernel_in   = ~kernel_in;
    norm_shift  = ~norm_shift;
    border_mode = ~border_mode;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (done) begin
        chk("done_timing", cyc, hs_cyc + 1);
        chk("done_busy", busy, 0);
        fin = 1;
      end else if (out_valid) begin
        if (abort_at >= 0 && nhs == abort_at) begin
          rst = 1'b1;
          #1;
          chk("abort_valid", out_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_data", out_data, 0);
          chk("abort_last", out_last, 0);
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_done", done, 0);
          end
          rst = 1'b0;
          @(negedge clk);
          chk("abort_idle_done", done, 0);
          return;
        end
        if (stall && nhs == 3 && stalls < 5) begin
          if (stalls == 0) begin
            held = out_data;
          end else begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, held);
          end
          out_ready = 1'b0;
          stalls++;
        end else begin
          if (stall && nhs == 3) chk("stall_data", out_data, held);
          out_ready = 1'b1;
          got_px[nhs]   = out_data;
          got_last[nhs] = out_last;
          nhs++;
          hs_cyc = cyc;
        end
      end
      start = (poke && nhs >= 10 && nhs < 12);
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!fin) chk("timeout", 0, 1);
    chk("handshakes", nhs, NPX);
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  // kind 0: identity; 1: all-ones zero pad on 10; 2: constant
  function automatic int expv(input int kind, input int cval,
                              input int r, input int c);
    int edges;
    if (kind == 0) return img_ref[r*IMG_W + c];
    if (kind == 2) return cval;
    edges = ((r == 0 || r == IMG_H-1) ? 1 : 0) +
            ((c == 0 || c == IMG_W-1) ? 1 : 0);
    return (edges == 2) ? 40 : (edges == 1) ? 60 : 90;
  endfunction

  task automatic check_frame(input string name, input int kind,
                             input int cval);
    for (int k = 0; k < nhs; k++) begin
      chk($sformatf("%s_px%0d", name, k), got_px[k],
          expv(kind, cval, k / IMG_W, k % IMG_W));
      chk($sformatf("%s_last%0d", name, k), got_last[k],
          (k == NPX-1) ? 1 : 0);
    end
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    rand_img();
    set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
    norm_shift = 0; border_mode = 0;
    run_frame(0, 0, -1);
    check_frame("ident", 0, 0);

    fill_img(10);
    set_kern(1, 1, 1, 1, 1, 1, 1, 1, 1);
    norm_shift = 0; border_mode = 0;
    run_frame(0, 0, -1);
    check_frame("ones_zero", 1, 0);

    fill_img(10);
    set_kern(1, 1, 1, 1, 1, 1, 1, 1, 1);
    norm_shift = 0; border_mode = 1;
    run_frame(0, 0, -1);
    check_frame("ones_repl", 2, 90);

    fill_img(16);
    set_kern(1, 2, 1, 2, 4, 2, 1, 2, 1);
    norm_shift = 4; border_mode = 1;
    run_frame(0, 0, -1);
    check_frame("gauss", 2, 16);

    fill_img(255);
    set_kern(1, 1, 1, 1, 1, 1, 1, 1, 1);
    norm_shift = 0; border_mode = 1;
    run_frame(0, 0, -1);
    check_frame("sat_hi", 2, 255);

    fill_img(50);
    set_kern(0, 0, 0, 0, -1, 0, 0, 0, 0);
    norm_shift = 0; border_mode = 0;
    run_frame(0, 0, -1);
    check_frame("neg", 2, 0);

    fill_img(200);
    set_kern(0, 0, 0, 0, 127, 0, 0, 0, 0);
    norm_shift = 7; border_mode = 0;
    run_frame(0, 0, -1);
    check_frame("c127", 2, 198);

    rand_img();
    set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
    norm_shift = 0; border_mode = 0;
    run_frame(1, 1, -1);
    check_frame("stall", 0, 0);

    rand_img();
    set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
    norm_shift = 0; border_mode = 0;
    run_frame(0, 0, 40);
    load_img();
    set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0);
    norm_shift = 0; border_mode = 0;
    run_frame(0, 0, -1);
    check_frame("after_abort", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
